// File: rtl/mem_if_pkg.sv
// Shared types and constants for the line memory responder.
package mem_if_pkg;

  localparam int DEF_LINE_ADDR_LEN = 3;
  localparam int DEF_MEM_ADDR_LEN  = 12;
  localparam int DEF_LATENCY       = 50;

  // Responder transaction state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

  // Number of 32-bit words in one cache line.
  function automatic int line_words(input int line_addr_len);
    return 32'sd1 << line_addr_len;
  endfunction

  localparam int WORDS_PER_LINE = line_words(DEF_LINE_ADDR_LEN);

endpackage

// File: rtl/mem_word_array.sv
// Word-addressed storage with one synchronous write port and one synchronous read port.
// Contents are deliberately not reset.
module mem_word_array #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [0:(1 << ADDR_W)-1];

  // Commit a write beat on the rising edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Registered read of the addressed word.
  always_ff @(posedge clk) begin
    rdata <= mem_q[raddr];
  end

endmodule

// File: rtl/line_mem_responder.sv
// Main-memory responder for D-cache line refills (reads) and writebacks (writes).
// A request is answered after LATENCY cycles with a word-serial burst of one line.
module line_mem_responder
  import mem_if_pkg::*;
#(
  parameter int LINE_ADDR_LEN = DEF_LINE_ADDR_LEN,
  parameter int MEM_ADDR_LEN  = DEF_MEM_ADDR_LEN,
  parameter int LATENCY       = DEF_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        rd_last,
  output logic        done,
  output logic        busy
);

  localparam int BASE_W = MEM_ADDR_LEN - LINE_ADDR_LEN;
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0]         CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [LINE_ADDR_LEN-1:0] BEAT_MAX = LINE_ADDR_LEN'(line_words(LINE_ADDR_LEN) - 1);

  mem_state_e               state_q, state_d;
  logic                     we_q, we_d;
  logic [BASE_W-1:0]        base_q, base_d;
  logic [LINE_ADDR_LEN-1:0] beat_q, beat_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic req_ready_q, req_ready_d;
  logic wr_ready_q, wr_ready_d;
  logic rd_valid_q, rd_valid_d;
  logic rd_last_q, rd_last_d;
  logic done_q, done_d;
  logic busy_q, busy_d;

  logic                    mem_we_s;
  logic [MEM_ADDR_LEN-1:0] mem_waddr_s;
  logic [MEM_ADDR_LEN-1:0] mem_raddr_s;
  logic [31:0]             mem_rdata_s;

  // Offset bits and bits above the memory size do not select a word.
  logic unused_addr_s;
  assign unused_addr_s = ^{req_addr[31:MEM_ADDR_LEN+2], req_addr[LINE_ADDR_LEN+1:0]};

  // State, transaction context and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      base_q      <= {BASE_W{1'b0}};
      beat_q      <= {LINE_ADDR_LEN{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      req_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      base_q      <= base_d;
      beat_q      <= beat_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      wr_ready_q  <= wr_ready_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  // Next state: accept in IDLE, count down latency, stream the line, pulse DONE.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    base_d  = base_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_WAIT;
          we_d    = req_we;
          base_d  = req_addr[MEM_ADDR_LEN+1:LINE_ADDR_LEN+2];
          beat_d  = {LINE_ADDR_LEN{1'b0}};
          cnt_d   = CNT_INIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = ST_XFER;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_XFER: begin
        if (we_q) begin
          // Write beats advance only when the initiator presents data.
          if (wr_valid) begin
            beat_d = beat_q + LINE_ADDR_LEN'(1);
            if (beat_q == BEAT_MAX) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_XFER;
            end
          end else begin
            beat_d = beat_q;
          end
        end else begin
          // Read beats stream every cycle; there is no backpressure.
          beat_d = beat_q + LINE_ADDR_LEN'(1);
          if (beat_q == BEAT_MAX) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_XFER;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the handshake outputs come straight from flops.
  always_comb begin
    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    wr_ready_d  = (state_d == ST_XFER) && we_d;
    rd_valid_d  = (state_d == ST_XFER) && !we_d;
    rd_last_d   = rd_valid_d && (beat_d == BEAT_MAX);
    mem_we_s    = (state_q == ST_XFER) && we_q && wr_valid;
    mem_waddr_s = {base_q, beat_q};
    // Reading at the upcoming beat lines the array output up with the beat being presented.
    mem_raddr_s = {base_q, beat_d};
  end

  mem_word_array #(
    .ADDR_W (MEM_ADDR_LEN),
    .DATA_W (32)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (mem_waddr_s),
    .wdata (wr_data),
    .raddr (mem_raddr_s),
    .rdata (mem_rdata_s)
  );

  assign req_ready = req_ready_q;
  assign wr_ready  = wr_ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;
  assign done      = done_q;
  assign busy      = busy_q;
  // The array output is already registered; qualifying it keeps the bus at zero outside read beats.
  assign rd_data   = rd_valid_q ? mem_rdata_s : 32'h0000_0000;

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder with LATENCY=4, 8-word lines, 4K-word memory.
module tb_line_mem_responder;
  import mem_if_pkg::*;

  localparam int LAT = 4;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, wr_data, rd_data;
  logic        wr_valid, wr_ready, rd_valid, rd_last, done, busy;

  int total;
  int bad;
  logic [31:0] rd_words [WORDS_PER_LINE];

  line_mem_responder #(
    .LINE_ADDR_LEN (3),
    .MEM_ADDR_LEN  (12),
    .LATENCY       (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_last   (rd_last),
    .done      (done),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pat(input logic [31:0] seed, input int k);
    return seed + (32'h0000_0011 * 32'(k + 1));
  endfunction

  // Write one line; wr_valid is held high except during the stall window.
  task automatic wr_line(input logic [31:0] addr, input logic [31:0] seed,
                         input int stall_beat, input int stall_len, input int abort_after,
                         output int first_rdy, output int done_t, output int ndone);
    int beat;
    int stall_left;
    logic commit;
    beat = 0; stall_left = stall_len; first_rdy = -1; done_t = -1; ndone = 0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr;
    wr_valid = 1'b1; wr_data = pat(seed, 0);
    step();
    req_valid = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if (wr_ready && first_rdy < 0) first_rdy = t;
      if (done) begin
        ndone++;
        if (done_t < 0) done_t = t;
      end
      if (done_t >= 0 && t >= done_t + 2) break;
      if (abort_after >= 0 && beat == abort_after) begin
        rst = 1'b1;
        #1;
        check_val("abort_busy", {31'd0, busy}, 32'd0);
        check_val("abort_req_ready", {31'd0, req_ready}, 32'd1);
        check_val("abort_wr_ready", {31'd0, wr_ready}, 32'd0);
        check_val("abort_done", {31'd0, done}, 32'd0);
        #1;
        rst = 1'b0;
        break;
      end
      if (beat < 8 && beat == stall_beat && stall_left > 0 && wr_ready) begin
        wr_valid = 1'b0;
        stall_left--;
      end else begin
        wr_valid = 1'b1;
        wr_data = pat(seed, (beat < 8) ? beat : 7);
      end
      commit = wr_ready && wr_valid;
      step();
      if (commit) beat++;
    end
    wr_valid = 1'b0;
    req_we = 1'b0;
  endtask

  // Read one line, capturing beats into rd_words.
  task automatic rd_line(input logic [31:0] addr, output int first_t, output int nvalid,
                         output int span_ok, output int last_idx, output int done_t, output int ndone);
    int last_t;
    first_t = -1; nvalid = 0; last_idx = -1; done_t = -1; ndone = 0; last_t = -1;
    for (int k = 0; k < WORDS_PER_LINE; k++) rd_words[k] = 32'hDEAD_BEEF;
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr;
    step();
    req_valid = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if (rd_valid) begin
        if (first_t < 0) first_t = t;
        if (nvalid < WORDS_PER_LINE) rd_words[nvalid] = rd_data;
        if (rd_last) last_idx = nvalid;
        nvalid++;
        last_t = t;
      end
      if (done) begin
        ndone++;
        if (done_t < 0) done_t = t;
      end
      if (done_t >= 0 && t >= done_t + 2) break;
      step();
    end
    span_ok = (nvalid > 0 && (last_t - first_t + 1) == nvalid) ? 1 : 0;
  endtask

  task automatic check_line(input string tag, input logic [31:0] seed_lo, input logic [31:0] seed_hi,
                            input int split);
    for (int k = 0; k < WORDS_PER_LINE; k++) begin
      check_val($sformatf("%s_w%0d", tag, k), rd_words[k], pat((k < split) ? seed_lo : seed_hi, k));
    end
  endtask

  initial begin
    int fr, dt, nd, ft, nv, sp, li, cnt, d1, d2, idle_t, busy_after;
    total = 0; bad = 0;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0;
    wr_valid = 1'b0; wr_data = 32'd0;

    // 1: asynchronous reset between edges, then quiet idle.
    #2 rst = 1'b1;
    #1;
    check_val("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check_val("rst_rd_last", {31'd0, rd_last}, 32'd0);
    check_val("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    check_val("rst_rd_data", rd_data, 32'd0);
    step(); step();
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done || rd_valid || busy) cnt++;
    end
    check_val("idle_quiet", 32'(cnt), 32'd0);

    // 2: write then read line 0x40.
    wr_line(32'h0000_0040, 32'h0, -1, 0, -1, fr, dt, nd);
    check_val("wr_first_ready", 32'(fr), 32'd4);
    check_val("wr_done_t", 32'(dt), 32'd12);
    check_val("wr_ndone", 32'(nd), 32'd1);
    rd_line(32'h0000_0040, ft, nv, sp, li, dt, nd);
    check_val("rd_first", 32'(ft), 32'd4);
    check_val("rd_nvalid", 32'(nv), 32'd8);
    check_val("rd_contig", 32'(sp), 32'd1);
    check_val("rd_last_idx", 32'(li), 32'd7);
    check_val("rd_done_t", 32'(dt), 32'd12);
    check_val("rd_ndone", 32'(nd), 32'd1);
    check_line("rd40", 32'h0, 32'h0, 8);

    // 3: write stall of 3 cycles at beat 4 on line 0x80.
    wr_line(32'h0000_0080, 32'h1000_0000, 4, 3, -1, fr, dt, nd);
    check_val("stall_first_ready", 32'(fr), 32'd4);
    check_val("stall_done_t", 32'(dt), 32'd15);
    check_val("stall_ndone", 32'(nd), 32'd1);
    rd_line(32'h0000_0080, ft, nv, sp, li, dt, nd);
    check_val("stall_rd_nvalid", 32'(nv), 32'd8);
    check_line("rd80", 32'h1000_0000, 32'h1000_0000, 8);

    // 4: aliasing within the line and above the memory size.
    rd_line(32'h0000_005C, ft, nv, sp, li, dt, nd);
    check_val("alias5c_nvalid", 32'(nv), 32'd8);
    check_line("rd5c", 32'h0, 32'h0, 8);
    rd_line(32'h0001_0040, ft, nv, sp, li, dt, nd);
    check_val("alias10040_nvalid", 32'(nv), 32'd8);
    check_line("rd10040", 32'h0, 32'h0, 8);

    // 5: req_valid held continuously across two reads.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0040;
    step();
    d1 = -1; d2 = -1; idle_t = -1; busy_after = -1; nv = 0;
    for (int t = 0; t < 60; t++) begin
      if (done) begin
        if (d1 < 0) d1 = t;
        else if (d2 < 0) d2 = t;
      end
      if (req_ready && idle_t < 0) idle_t = t;
      if (idle_t >= 0 && t == idle_t + 1) busy_after = busy ? 1 : 0;
      if (rd_valid) nv++;
      if (d2 >= 0) break;
      step();
    end
    req_valid = 1'b0;
    step(); step();
    check_val("b2b_done1", 32'(d1), 32'd12);
    check_val("b2b_idle_t", 32'(idle_t), 32'd13);
    check_val("b2b_busy_after", 32'(busy_after), 32'd1);
    check_val("b2b_done2", 32'(d2), 32'd26);
    check_val("b2b_nvalid", 32'(nv), 32'd16);
    check_val("b2b_final_idle", {31'd0, req_ready}, 32'd1);

    // 6: reset after 3 write beats; older words 3..7 must survive.
    wr_line(32'h0000_0040, 32'h2000_0000, -1, 0, 3, fr, dt, nd);
    check_val("abort_ndone", 32'(nd), 32'd0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done || busy) cnt++;
    end
    check_val("abort_quiet", 32'(cnt), 32'd0);
    rd_line(32'h0000_0040, ft, nv, sp, li, dt, nd);
    check_val("abort_rd_nvalid", 32'(nv), 32'd8);
    check_line("rdab", 32'h2000_0000, 32'h0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
